sync_fifo_ctrl: RTL and testbench
=================================

Name: sync_fifo_ctrl

Overview:
- Single-clock FIFO controller that drives a single-port, combinational-read, synchronous-write word memory (a Memory_synth instance) over its re/we/addr/data_in/data_out interface.
- Adds valid/ready handshakes on the push and pop sides.
- Adds a one-entry output register, which enables a push-to-pop bypass when the memory holds no words.
- Sits between a producer (e.g. synchronized input logic) and the memory, and presents a streaming interface to the consumer.

Parameters:
- DW, 8, data word width; must equal the memory dw.
- DEPTH, 16, number of memory words; power of two, ≥2; must equal the memory w.
- AW, $clog2(DEPTH), memory address width (derived).
- CW, $clog2(DEPTH+2), occupancy count width (derived).

Ports:
- clock  input  1  system clock, all state on posedge
- reset_L  input  1  asynchronous, active-low reset
- flush  input  1  synchronous clear of all contents, active high
- push_valid  input  1  producer offers push_data
- push_ready  output  1  controller accepts push_data this cycle
- push_data  input  DW  write word
- pop_valid  output  1  pop_data holds the head word
- pop_ready  input  1  consumer takes the head word this cycle
- pop_data  output  DW  head word, driven from the output register
- mem_re  output  1  memory read enable
- mem_we  output  1  memory write enable
- mem_addr  output  AW  memory address
- mem_data_in  output  DW  memory write data; always equals push_data
- mem_data_out  input  DW  memory combinational read data
- count  output  CW  total occupancy: words in memory plus the output register
- full  output  1  count == DEPTH+1
- empty  output  1  count == 0

Behaviour:
- Reset (async, reset_L low): state resets to zero.
  - Clears wr_ptr, rd_ptr, mcount (0..DEPTH) and ovalid.
  - odata resets to 0.
  - While reset_L is low, push_ready, mem_we and mem_re are forced to 0.
- A transfer happens when valid && ready on a clock edge. pop_valid = ovalid; pop_data = odata.
- slot_free = !ovalid || pop_ready.
- Exactly one memory access is allowed per cycle. Case selection, in priority order:
  1. flush=1: push_ready=0, mem_we=mem_re=0. Next state: pointers, mcount and ovalid all 0.
  2. read_grant (slot_free && mcount!=0):
     - mem_re=1, mem_addr=rd_ptr, push_ready=0.
     - Next: odata<=mem_data_out, ovalid<=1, rd_ptr+1 (wraps DEPTH-1→0), mcount-1.
  3. bypass (slot_free && mcount==0):
     - push_ready=1, no memory access.
     - On push: odata<=push_data, ovalid<=1.
     - Otherwise, if a pop occurred: ovalid<=0.
     - Push-to-pop latency is 1 cycle.
  4. hold (!slot_free):
     - push_ready = (mcount!=DEPTH).
     - On push: mem_we=1, mem_addr=wr_ptr, wr_ptr+1 (wraps), mcount+1.
- Idle cycles: mem_addr=rd_ptr, mem_re=mem_we=0.
- Ordering is strict FIFO across bypass, memory and the output register.
  - Bypass only occurs with mcount==0, so words are never reordered.
- Read wins over push when both are possible. With continuous popping and mcount>0, pushes stall until the memory drains. This throughput limit is intended and follows from the single port.
- count = mcount + ovalid.
  - Total capacity is DEPTH+1.
  - full and empty are combinational from registered state.
- Push when push_ready=0: ignored, state unchanged, no error.
- Pop when pop_valid=0: ignored.
- Reset mid-operation discards all contents immediately. Memory contents are not cleared and are don't-care.

Test Plan:
- Bypass: after reset, push 0xA5 → mem_we stays 0; next cycle pop_valid=1, pop_data=0xA5, count=1.
- Fill: pop_ready=0, push 1..17 → word 1 lands in the output register; words 2..17 are written to addresses 0..15. Then push_ready=0, full=1, count=17, and an 18th push is ignored.
- Drain: from full, pop_ready=1 held → pop_data = 1..17 on consecutive cycles; mem_re=1 for 16 cycles; then empty=1, pop_valid=0.
- Wrap: push/pop sequences that advance wr_ptr and rd_ptr past 15→0 three times, with random valid/ready → output sequence equals input sequence and count matches the model.
- Contention: ovalid=1, mcount=3, push_valid=pop_ready=1 → mem_re=1 and push_ready=0 that cycle; push accepted once mcount==0.
- Flush/reset: with count=5, assert flush for one cycle → count=0, pop_valid=0 next cycle. Pulse reset_L low mid-fill → outputs clear asynchronously and push_ready=0 while low.

Source files
------------

// File: rtl/sync_fifo_ctrl_if.sv
// Push/pop handshake, status and memory-port bundle for sync_fifo_ctrl.
// master is the controller side; slave is the producer/consumer/memory side.
interface sync_fifo_ctrl_if #(
  parameter int unsigned DW    = 8,
  parameter int unsigned DEPTH = 16
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 2);

  logic          flush;
  logic          push_valid;
  logic          push_ready;
  logic [DW-1:0] push_data;
  logic          pop_valid;
  logic          pop_ready;
  logic [DW-1:0] pop_data;
  logic          mem_re;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data_in;
  logic [DW-1:0] mem_data_out;
  logic [CW-1:0] count;
  logic          full;
  logic          empty;

  modport master (
    input  flush, push_valid, push_data, pop_ready, mem_data_out,
    output push_ready, pop_valid, pop_data, mem_re, mem_we, mem_addr,
           mem_data_in, count, full, empty
  );

  modport slave (
    output flush, push_valid, push_data, pop_ready, mem_data_out,
    input  push_ready, pop_valid, pop_data, mem_re, mem_we, mem_addr,
           mem_data_in, count, full, empty
  );
endinterface

// File: rtl/sync_fifo_ctrl.sv
// Single-port FIFO controller: one memory access per cycle, a one-entry output
// register, and a push-to-pop bypass whenever the memory holds no words.
module sync_fifo_ctrl #(
  parameter int unsigned DW    = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic             clock,
  input  logic             reset_L,
  sync_fifo_ctrl_if.master bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 2);

  logic [AW-1:0] wr_ptr, wr_ptr_n;
  logic [AW-1:0] rd_ptr, rd_ptr_n;
  logic [CW-1:0] mcount, mcount_n;
  logic          ovalid, ovalid_n;
  logic [DW-1:0] odata, odata_n;

  logic          slot_free;
  logic          mem_has_data;
  logic          push_ready_c;
  logic          mem_re_c;
  logic          mem_we_c;
  logic [AW-1:0] mem_addr_c;

  // State register
  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      mcount <= '0;
      ovalid <= 1'b0;
      odata  <= '0;
    end else begin
      wr_ptr <= wr_ptr_n;
      rd_ptr <= rd_ptr_n;
      mcount <= mcount_n;
      ovalid <= ovalid_n;
      odata  <= odata_n;
    end
  end

  assign slot_free    = !ovalid || bus.pop_ready;
  assign mem_has_data = (mcount != '0);

  // Access arbitration: flush, then refill the output register, then bypass, then write
  always_comb begin
    wr_ptr_n     = wr_ptr;
    rd_ptr_n     = rd_ptr;
    mcount_n     = mcount;
    ovalid_n     = ovalid;
    odata_n      = odata;
    push_ready_c = 1'b0;
    mem_re_c     = 1'b0;
    mem_we_c     = 1'b0;
    mem_addr_c   = rd_ptr;

    if (bus.flush) begin
      wr_ptr_n = '0;
      rd_ptr_n = '0;
      mcount_n = '0;
      ovalid_n = 1'b0;
    end else if (slot_free && mem_has_data) begin
      mem_re_c = 1'b1;
      odata_n  = bus.mem_data_out;
      ovalid_n = 1'b1;
      rd_ptr_n = rd_ptr + AW'(1);
      mcount_n = mcount - CW'(1);
    end else if (slot_free) begin
      push_ready_c = 1'b1;
      if (bus.push_valid) begin
        odata_n  = bus.push_data;
        ovalid_n = 1'b1;
      end else if (ovalid && bus.pop_ready) begin
        ovalid_n = 1'b0;
      end
    end else begin
      push_ready_c = (mcount != CW'(DEPTH));
      if (bus.push_valid && push_ready_c) begin
        mem_we_c   = 1'b1;
        mem_addr_c = wr_ptr;
        wr_ptr_n   = wr_ptr + AW'(1);
        mcount_n   = mcount + CW'(1);
      end
    end
  end

  // Handshake and memory strobes are held low while reset is asserted
  assign bus.push_ready  = push_ready_c && reset_L;
  assign bus.mem_re      = mem_re_c && reset_L;
  assign bus.mem_we      = mem_we_c && reset_L;
  assign bus.mem_addr    = mem_addr_c;
  assign bus.mem_data_in = bus.push_data;

  assign bus.pop_valid = ovalid;
  assign bus.pop_data  = odata;
  assign bus.count     = mcount + CW'(ovalid);
  assign bus.full      = (bus.count == CW'(DEPTH + 1));
  assign bus.empty     = (bus.count == '0);
endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Scoreboard bench for sync_fifo_ctrl with a behavioural memory and FIFO model.
module tb_sync_fifo_ctrl;
  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 16;

  logic clock;
  logic reset_L;

  sync_fifo_ctrl_if #(.DW(DW), .DEPTH(DEPTH)) bus ();

  sync_fifo_ctrl #(.DW(DW), .DEPTH(DEPTH)) dut (
    .clock   (clock),
    .reset_L (reset_L),
    .bus     (bus)
  );

  logic [DW-1:0] mem [DEPTH];
  always @(posedge clock) if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_data_in;
  assign bus.mem_data_out = mem[bus.mem_addr];

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;
  int re_cnt = 0;
  int we_cnt = 0;
  logic [DW-1:0] exp_q [$];

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endfunction

  // Monitor: model-derived status checks and scoreboard pops on every pop handshake
  always @(negedge clock) begin
    int sz, m;
    logic sf, e_pr, e_re, e_we;
    if (!reset_L) begin
      chk("rst_push_ready", 32'(bus.push_ready), 0);
      chk("rst_mem_we", 32'(bus.mem_we), 0);
      chk("rst_mem_re", 32'(bus.mem_re), 0);
      chk("rst_count", 32'(bus.count), 0);
    end else begin
      if (bus.mem_re) re_cnt++;
      if (bus.mem_we) we_cnt++;
      sz   = exp_q.size();
      m    = (sz > 0) ? sz - 1 : 0;
      sf   = (sz == 0) || bus.pop_ready;
      e_pr = bus.flush ? 1'b0 : (sf ? (m == 0) : (m != int'(DEPTH)));
      e_re = !bus.flush && sf && (m > 0);
      e_we = !bus.flush && !sf && (m != int'(DEPTH)) && bus.push_valid;
      chk("count", 32'(bus.count), 32'(sz));
      chk("full", 32'(bus.full), 32'(sz == int'(DEPTH) + 1));
      chk("empty", 32'(bus.empty), 32'(sz == 0));
      chk("pop_valid", 32'(bus.pop_valid), 32'(sz > 0));
      chk("push_ready", 32'(bus.push_ready), 32'(e_pr));
      chk("mem_re", 32'(bus.mem_re), 32'(e_re));
      chk("mem_we", 32'(bus.mem_we), 32'(e_we));
      if (!bus.flush && bus.pop_valid && bus.pop_ready) begin
        if (sz == 0) chk("pop_unexpected", 1, 0);
        else chk("pop_data", 32'(bus.pop_data), 32'(exp_q.pop_front()));
      end
    end
  end

  // One cycle of stimulus; records accepted pushes and flushes into the scoreboard
  task automatic cyc(input logic pv, input logic [DW-1:0] pd, input logic pr,
                     input logic fl, output logic acc, output logic re);
    bus.push_valid = pv;
    bus.push_data  = pd;
    bus.pop_ready  = pr;
    bus.flush      = fl;
    #1;
    re  = bus.mem_re;
    acc = pv && bus.push_ready && !fl;
    @(negedge clock);
    #1;
    if (reset_L) begin
      if (fl) exp_q.delete();
      else if (acc) exp_q.push_back(pd);
    end
    @(posedge clock);
    #1;
  endtask

  initial begin
    logic acc, re;
    int stalls, re0, pv_pct, pr_pct;

    reset_L        = 1'b0;
    bus.flush      = 1'b0;
    bus.push_valid = 1'b0;
    bus.push_data  = '0;
    bus.pop_ready  = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    chk("reset_count", 32'(bus.count), 0);
    chk("reset_empty", 32'(bus.empty), 1);
    chk("reset_pop_data", 32'(bus.pop_data), 0);
    reset_L = 1'b1;

    // Bypass into empty FIFO: no memory write, word visible next cycle
    bus.push_valid = 1'b1;
    bus.push_data  = 8'hA5;
    #1;
    chk("byp_mem_we", 32'(bus.mem_we), 0);
    cyc(1, 8'hA5, 0, 0, acc, re);
    chk("byp_pop_valid", 32'(bus.pop_valid), 1);
    chk("byp_pop_data", 32'(bus.pop_data), 32'hA5);
    chk("byp_count", 32'(bus.count), 1);
    cyc(0, 0, 1, 0, acc, re);

    // Fill to DEPTH+1, then an extra push must be refused
    for (int i = 1; i <= 17; i++) cyc(1, DW'(i), 0, 0, acc, re);
    chk("fill_full", 32'(bus.full), 1);
    chk("fill_count", 32'(bus.count), 17);
    cyc(1, 8'hEE, 0, 0, acc, re);
    chk("fill_18th_accepted", 32'(acc), 0);

    // Drain with pop_ready held
    re0 = re_cnt;
    for (int i = 0; i < 17; i++) cyc(0, 0, 1, 0, acc, re);
    chk("drain_reads", 32'(re_cnt - re0), 16);
    chk("drain_empty", 32'(bus.empty), 1);
    chk("drain_pop_valid", 32'(bus.pop_valid), 0);

    // Contention: output register full and three words in memory
    for (int i = 0; i < 4; i++) cyc(1, DW'(8'h40 + i), 0, 0, acc, re);
    chk("cont_count", 32'(bus.count), 4);
    stalls = 0;
    for (int i = 0; i < 10; i++) begin
      cyc(1, 8'h77, 1, 0, acc, re);
      if (i == 0) chk("cont_first_re", 32'(re), 1);
      if (acc) break;
      stalls++;
    end
    chk("cont_stalls", 32'(stalls), 3);
    for (int i = 0; i < 4; i++) cyc(0, 0, 1, 0, acc, re);

    // Flush with five entries
    for (int i = 0; i < 5; i++) cyc(1, DW'(8'h50 + i), 0, 0, acc, re);
    chk("flush_pre_count", 32'(bus.count), 5);
    cyc(0, 0, 0, 1, acc, re);
    chk("flush_count", 32'(bus.count), 0);
    chk("flush_pop_valid", 32'(bus.pop_valid), 0);

    // Asynchronous reset in the middle of a fill
    for (int i = 0; i < 3; i++) cyc(1, DW'(8'h60 + i), 0, 0, acc, re);
    reset_L = 1'b0;
    #1;
    chk("arst_count", 32'(bus.count), 0);
    chk("arst_pop_valid", 32'(bus.pop_valid), 0);
    chk("arst_push_ready", 32'(bus.push_ready), 0);
    exp_q.delete();
    @(posedge clock);
    #1;
    reset_L = 1'b1;

    // Randomised traffic with varying push/pop pressure and rare flushes
    for (int i = 0; i < 1200; i++) begin
      if (i % 100 == 0) begin
        pv_pct = $urandom_range(30, 95);
        pr_pct = $urandom_range(20, 90);
      end
      cyc($urandom_range(0, 99) < pv_pct, DW'($urandom), $urandom_range(0, 99) < pr_pct,
          $urandom_range(0, 199) == 0, acc, re);
    end
    for (int i = 0; i < 40; i++) cyc(0, 0, 1, 0, acc, re);
    chk("wrap_writes", 32'(we_cnt >= 3 * int'(DEPTH)), 1);
    chk("final_empty", 32'(bus.empty), 1);
    chk("final_queue", 32'(exp_q.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
